// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes and instruction field positions.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [5:0] OPC_ADD  = 6'd2;
  localparam logic [5:0] OPC_ADDI = 6'd6;
  localparam logic [5:0] OPC_BR   = 6'd8;
  localparam logic [5:0] OPC_JUMP = 6'd9;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JT_HI  = 25;
  localparam int JT_LO  = 0;

  function automatic logic [5:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  // Only the low ADDR_W bits of the jump field address the ROM.
  function automatic logic [ADDR_W-1:0] jtarget_of(input logic [DATA_W-1:0] word);
    logic [JT_HI-JT_LO:0] field;
    field = word[JT_HI:JT_LO];
    return field[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: redirect, local jump, increment (wraps).
module pc_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              advance,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    addr_next = addr_reg;
    if (br_taken)
      addr_next = br_target;
    else if (advance)
      addr_next = jump ? jump_target : ADDR_W'(addr_reg + 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      addr_reg <= '0;
    else
      addr_reg <= addr_next;
  end

  assign pc = addr_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register and fetched-instruction counter.
// Optional halt-on-zero-word behaviour is enabled by defining FETCH_HALT_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  output logic              if_is_jump,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic              halted
);

  logic              normal;
  logic              zero_word;
  logic              advance;
  logic              is_jump;
  logic              halted_reg;
  logic [ADDR_W-1:0] pc;

  logic [DATA_W-1:0] if_instr_reg;
  logic [ADDR_W-1:0] if_pc_reg;
  logic              if_valid_reg;
  logic              if_is_jump_reg;
  logic [CNT_W-1:0]  fetch_cnt_reg;

  assign normal  = !br_taken && !stall && !halted_reg;
  assign is_jump = (opcode_of(imem_instr) == OPC_JUMP);

`ifdef FETCH_HALT_EN
  assign zero_word = (imem_instr == '0);

  // Once set, only a redirect or reset releases the halt; stall is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted_reg <= 1'b0;
    else if (br_taken)
      halted_reg <= 1'b0;
    else if (normal && zero_word)
      halted_reg <= 1'b1;
  end
`else
  assign zero_word  = 1'b0;
  assign halted_reg = 1'b0;
`endif

  assign advance = normal && !zero_word;

  pc_reg u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .advance     (advance),
    .jump        (is_jump),
    .jump_target (jtarget_of(imem_instr)),
    .pc          (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_instr_reg   <= '0;
      if_pc_reg      <= '0;
      if_valid_reg   <= 1'b0;
      if_is_jump_reg <= 1'b0;
      fetch_cnt_reg  <= '0;
    end else if (br_taken) begin
      if_valid_reg   <= 1'b0;
      if_is_jump_reg <= 1'b0;
    end else if (advance) begin
      if_instr_reg   <= imem_instr;
      if_pc_reg      <= pc;
      if_valid_reg   <= 1'b1;
      if_is_jump_reg <= is_jump;
      if (fetch_cnt_reg != '1)
        fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
    end else if (normal) begin
      // Reached only when a zero word trips the halt.
      if_valid_reg <= 1'b0;
    end
  end

  assign imem_addr  = pc;
  assign if_instr   = if_instr_reg;
  assign if_pc      = if_pc_reg;
  assign if_valid   = if_valid_reg;
  assign if_is_jump = if_is_jump_reg;
  assign fetch_cnt  = fetch_cnt_reg;
  assign halted     = halted_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle reference model plus directed literal checks.
module tb_fetch_stage;
  import cpu_pkg::*;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [4:0]  br_target;
  logic [4:0]  imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [4:0]  if_pc;
  logic        if_valid;
  logic        if_is_jump;
  logic [15:0] fetch_cnt;
  logic        halted;

  logic [31:0] rom [32];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  assign imem_instr = rom[imem_addr];

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .if_is_jump (if_is_jump),
    .fetch_cnt  (fetch_cnt),
    .halted     (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage's architectural state, advanced by the rules per edge.
  logic [4:0]  m_pc;
  logic [31:0] m_instr;
  logic [4:0]  m_ifpc;
  logic        m_valid;
  logic        m_jump;
  logic [15:0] m_cnt;
  logic        m_halted;

  always @(posedge clk or posedge rst) begin
    logic [31:0] w;
    if (rst) begin
      m_pc <= 0; m_instr <= 0; m_ifpc <= 0; m_valid <= 0;
      m_jump <= 0; m_cnt <= 0; m_halted <= 0;
    end else if (br_taken) begin
      m_pc <= br_target; m_valid <= 0; m_jump <= 0; m_halted <= 0;
    end else if (!(HALT_EN && m_halted) && !stall) begin
      w = rom[m_pc];
      if (HALT_EN && w == 32'd0) begin
        m_halted <= 1; m_valid <= 0;
      end else begin
        m_instr <= w;
        m_ifpc  <= m_pc;
        m_valid <= 1;
        m_jump  <= (w[31:26] == 6'd9);
        m_pc    <= (w[31:26] == 6'd9) ? w[4:0] : m_pc + 5'd1;
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    $display("cyc %0d rst=%0b stall=%0b br=%0b pc=%0d if_pc=%0d if_instr=%08h valid=%0b jump=%0b cnt=%0d halted=%0b",
             cyc, rst, stall, br_taken, imem_addr, if_pc, if_instr, if_valid, if_is_jump, fetch_cnt, halted);
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("if_instr", if_instr, m_instr);
    check("if_pc", 32'(if_pc), 32'(m_ifpc));
    check("if_valid", 32'(if_valid), 32'(m_valid));
    check("if_is_jump", 32'(if_is_jump), 32'(m_jump));
    check("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
    check("halted", 32'(halted), 32'(m_halted));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_instr"}, if_instr, 32'd0);
    check({tag, "_pc"}, 32'(if_pc), 32'd0);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_jump"}, 32'(if_is_jump), 32'd0);
    check({tag, "_cnt"}, 32'(fetch_cnt), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  initial begin
    int exp1 [8];
    int exp2 [4];
    exp1 = '{0, 1, 2, 3, 4, 5, 12, 13};
    exp2 = '{30, 31, 0, 1};
    for (int i = 0; i < 32; i++) rom[i] = {OPC_ADD, 26'(i)};
    rom[5]  = {OPC_JUMP, 21'h15555, 5'd12};   // upper field bits must be ignored
    rom[19] = {OPC_JUMP, 21'h0, 5'd14};
    rom[7]  = 32'd0;

    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 5'd0;
    #1;
    check_zero("reset");
    step();
    rst = 1'b0;

    // Jump at 5 to 12
    for (int k = 0; k < 8; k++) begin
      step();
      check("t1_if_pc", 32'(if_pc), 32'(exp1[k]));
      check("t1_jump", 32'(if_is_jump), (k == 5) ? 32'd1 : 32'd0);
    end
    check("t1_cnt", 32'(fetch_cnt), 32'd8);
    check("t1_pc", 32'(imem_addr), 32'd14);

    // Redirect to 30, then wrap 31 -> 0
    br_taken = 1'b1; br_target = 5'd30;
    step();
    br_taken = 1'b0;
    check("t2_flush_valid", 32'(if_valid), 32'd0);
    check("t2_redirect_pc", 32'(imem_addr), 32'd30);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_if_pc", 32'(if_pc), 32'(exp2[k]));
      check("t2_valid", 32'(if_valid), 32'd1);
    end

    // Stall three cycles at if_pc=3
    step();
    step();
    check("t3_if_pc_pre", 32'(if_pc), 32'd3);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_hold_if_pc", 32'(if_pc), 32'd3);
      check("t3_hold_pc", 32'(imem_addr), 32'd4);
      check("t3_hold_instr", if_instr, 32'h0800_0003);
    end
    stall = 1'b0;
    step();
    check("t3_resume", 32'(if_pc), 32'd4);
    check("t3_cnt", 32'(fetch_cnt), 32'd15);

    // Redirect overrides stall
    stall = 1'b1; br_taken = 1'b1; br_target = 5'd14;
    step();
    stall = 1'b0; br_taken = 1'b0;
    check("t4_pc", 32'(imem_addr), 32'd14);
    check("t4_valid", 32'(if_valid), 32'd0);
    check("t4_if_pc_hold", 32'(if_pc), 32'd4);
    step();
    check("t4_if_pc", 32'(if_pc), 32'd14);
    check("t4_valid2", 32'(if_valid), 32'd1);

    // Loop 14..19, then asynchronous reset mid-cycle
    for (int k = 0; k < 20; k++) begin
      step();
      check("t5_in_loop", 32'((imem_addr >= 5'd14) && (imem_addr <= 5'd19)), 32'd1);
    end
    #1;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    step();
    rst = 1'b0;

    // Zero word at address 7
    br_taken = 1'b1; br_target = 5'd6;
    step();
    br_taken = 1'b0;
    step();
    check("t6_if_pc6", 32'(if_pc), 32'd6);
    check("t6_cnt1", 32'(fetch_cnt), 32'd1);
    step();
`ifdef FETCH_HALT_EN
    check("t6_halted", 32'(halted), 32'd1);
    check("t6_valid", 32'(if_valid), 32'd0);
    check("t6_pc", 32'(imem_addr), 32'd7);
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    step();
    check("t6_stuck_pc", 32'(imem_addr), 32'd7);
    check("t6_stuck_cnt", 32'(fetch_cnt), 32'd1);
    check("t6_stuck_halted", 32'(halted), 32'd1);
    br_taken = 1'b1; br_target = 5'd0;
    step();
    br_taken = 1'b0;
    check("t6_release", 32'(halted), 32'd0);
    check("t6_release_pc", 32'(imem_addr), 32'd0);
    step();
    check("t6_restart_if_pc", 32'(if_pc), 32'd0);
    check("t6_restart_valid", 32'(if_valid), 32'd1);
`else
    check("t6_zero_valid", 32'(if_valid), 32'd1);
    check("t6_zero_if_pc", 32'(if_pc), 32'd7);
    check("t6_zero_instr", if_instr, 32'd0);
    check("t6_zero_pc", 32'(imem_addr), 32'd8);
    check("t6_zero_cnt", 32'(fetch_cnt), 32'd2);
    check("t6_no_halt", 32'(halted), 32'd0);
    step();
    check("t6_next_if_pc", 32'(if_pc), 32'd8);
`endif

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
